registrador_universal: RTL and testbench

//  Parametrised successor of the team's 8-bit enable/clear register. Adds

---
 rtl/registrador_universal.sv | 113 +++++++++++
 tb/tb_registrador_universal.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/registrador_universal.sv
// Universal register: load, shift/rotate, sync clear and a self-timed serial burst on sout.
// Optional even parity output enabled by defining REGISTRADOR_PARITY_EN.
module registrador_universal #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             parity
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] shl_sin, shr_sin, rol, ror;

    // A single-bit word has no neighbours: shifts take sin, rotates hold.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl_sin = sin;
            assign shr_sin = sin;
            assign rol     = data_q;
            assign ror     = data_q;
        end else begin : g_wn
            assign shl_sin = {data_q[WIDTH-2:0], sin};
            assign shr_sin = {sin, data_q[WIDTH-1:1]};
            assign rol     = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            assign ror     = {data_q[0], data_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            data_q  <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en && mode == 3'b111) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    case (mode)
                        3'b000: data_d = data_q;
                        3'b001: data_d = d;
                        3'b010: data_d = shl_sin;
                        3'b011: data_d = shr_sin;
                        3'b100: data_d = rol;
                        3'b101: data_d = ror;
                        3'b110: data_d = RESET_VAL;
                        3'b111: cnt_d  = '0;
                    endcase
                end
            end
            SHIFT: begin
                data_d = shr_sin;
                // Counter saturates on the last shift so it never wraps.
                if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    assign q    = data_q;
    assign sout = data_q[0];

`ifdef REGISTRADOR_PARITY_EN
    assign parity = ^data_q;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_registrador_universal.sv
// Self-checking bench: three instances (W=8, W=8 with RESET_VAL=5A, W=1) share stimulus
// and are compared against an arithmetic reference model.
module tb_registrador_universal;

    logic       clk = 1'b1;
    logic       rstn;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;

    logic [7:0] q8, qrv;
    logic [0:0] q1;
    logic       sout8, busy8, done8, par8;
    logic       soutrv, busyrv, donerv, parrv;
    logic       sout1, busy1, done1, par1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    registrador_universal #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q8), .sout(sout8), .busy(busy8), .done(done8), .parity(par8));

    registrador_universal #(.WIDTH(8), .RESET_VAL(8'h5A)) dut_rv (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(qrv), .sout(soutrv), .busy(busyrv), .done(donerv), .parity(parrv));

    registrador_universal #(.WIDTH(1), .RESET_VAL(1'b0)) dut_w1 (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d[0:0]), .sin(sin),
        .q(q1), .sout(sout1), .busy(busy1), .done(done1), .parity(par1));

    // Reference model: per instance, word value, remaining burst shifts, done flag.
    int         mw[3]  = '{8, 8, 1};
    logic [7:0] mrv[3] = '{8'h00, 8'h5A, 8'h00};
    logic [7:0] mq[3];
    int         mleft[3];
    bit         mdone[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mask_of(input int w);
        logic [8:0] t;
        t = (9'd1 << w) - 9'd1;
        return t[7:0];
    endfunction

    function automatic logic exp_parity(input logic [7:0] v);
`ifdef REGISTRADOR_PARITY_EN
        return ^v;
`else
        return 1'b0 & v[0];
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i]    = mrv[i];
            mleft[i] = 0;
            mdone[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [7:0] m, s8, v;
        if (!rstn) begin
            model_reset();
            return;
        end
        s8 = {7'b0, sin};
        for (int i = 0; i < 3; i++) begin
            m = mask_of(mw[i]);
            v = mq[i];
            if (mleft[i] > 0) begin
                v = (v >> 1) | (s8 << (mw[i] - 1));
                mleft[i]--;
                if (mleft[i] == 0) mdone[i] = 1;
            end else if (mdone[i]) begin
                mdone[i] = 0;
            end else if (en) begin
                case (mode)
                    3'd1: v = d;
                    3'd2: v = (v << 1) | s8;
                    3'd3: v = (v >> 1) | (s8 << (mw[i] - 1));
                    3'd4: v = (v << 1) | (v >> (mw[i] - 1));
                    3'd5: v = (v >> 1) | ((v & 8'd1) << (mw[i] - 1));
                    3'd6: v = mrv[i];
                    3'd7: mleft[i] = mw[i];
                    default: ;
                endcase
            end
            mq[i] = v & m;
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] oq;
        logic       os, ob, od, op;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin oq = q8;          os = sout8;  ob = busy8;  od = done8;  op = par8;  end
                1:       begin oq = qrv;         os = soutrv; ob = busyrv; od = donerv; op = parrv; end
                default: begin oq = {7'b0, q1};  os = sout1;  ob = busy1;  od = done1;  op = par1;  end
            endcase
            check($sformatf("%s_q%0d", tag, i),    oq, mq[i]);
            check($sformatf("%s_sout%0d", tag, i), os, mq[i][0]);
            check($sformatf("%s_busy%0d", tag, i), ob, mleft[i] > 0);
            check($sformatf("%s_done%0d", tag, i), od, mdone[i]);
            check($sformatf("%s_par%0d", tag, i),  op, exp_parity(mq[i]));
        end
    endtask

    // Called at a rising edge; drives inputs, lets one falling edge act, checks, returns at next rising edge.
    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dv, input logic s,
                        input string tag);
        en = e; mode = m; d = dv; sin = s;
        @(negedge clk);
        model_step();
        #1 check_all(tag);
        @(posedge clk);
    endtask

    task automatic async_reset(input string tag);
        rstn = 1'b0;
        #1 model_reset();
        check_all(tag);
    endtask

    logic [7:0] pat;

    initial begin
        rstn = 1'b0; en = 1'b1; mode = 3'b001; d = 8'hA5; sin = 1'b0;
        model_reset();
        @(posedge clk);

        // Reset dominates a pending load, then the load lands on the first edge after release.
        step(1, 3'b001, 8'hA5, 0, "t1_rst");
        check("t1_q_in_reset", q8, 8'h00);
        rstn = 1'b1;
        step(1, 3'b001, 8'hA5, 0, "t1_load");
        check("t1_q_loaded", q8, 8'hA5);

        // Shift and rotate from 0x81.
        step(1, 3'b001, 8'h81, 0, "t2_ld");
        step(1, 3'b100, 8'h00, 0, "t2_rol");   check("t2_rol_c", q8, 8'h03);
        step(1, 3'b101, 8'h00, 0, "t2_ror");   check("t2_ror_c", q8, 8'h81);
        step(1, 3'b010, 8'h00, 1, "t2_shl");   check("t2_shl_c", q8, 8'h03);
        step(1, 3'b001, 8'h81, 0, "t2_ld2");
        step(1, 3'b011, 8'h00, 0, "t2_shr");   check("t2_shr_c", q8, 8'h40);
        step(0, 3'b001, 8'hFF, 1, "t2_en0");   check("t2_en0_c", q8, 8'h40);
        step(0, 3'b111, 8'hFF, 1, "t2_en0b");  check("t2_en0b_c", busy8, 1'b0);

        // Burst of 0xB4 with sin=0.
        pat = 8'hB4;
        step(1, 3'b001, pat, 0, "t3_ld");
        step(1, 3'b111, 8'h00, 0, "t3_go");
        check("t3_sout0", sout8, pat[0]);
        check("t3_busy0", busy8, 1'b1);
        for (int k = 1; k < 8; k++) begin
            step(0, 3'b000, 8'h00, 0, "t3_sh");
            check($sformatf("t3_sout%0d", k), sout8, pat[k]);
            check($sformatf("t3_busy%0d", k), busy8, 1'b1);
        end
        step(0, 3'b000, 8'h00, 0, "t3_end");
        check("t3_done", done8, 1'b1);
        check("t3_notbusy", busy8, 1'b0);
        check("t3_q", q8, 8'h00);
        step(1, 3'b001, 8'h77, 0, "t3_post");
        check("t3_done_gone", done8, 1'b0);
        check("t3_cmd_ignored_in_done", q8, 8'h00);

        // Commands ignored mid-burst, then async reset mid-burst.
        step(1, 3'b001, 8'hC3, 0, "t4_ld");
        step(1, 3'b111, 8'h00, 1, "t4_go");
        for (int k = 0; k < 3; k++) step(0, 3'b000, 8'h00, 1, "t4_sh");
        step(1, 3'b001, 8'h00, 1, "t4_cmd");
        step(1, 3'b001, 8'h00, 0, "t4_sh5");
        check("t4_still_busy", busy8, 1'b1);
        async_reset("t4_async");
        check("t4_q", q8, 8'h00);
        check("t4_q_rv", qrv, 8'h5A);
        check("t4_busy", busy8, 1'b0);
        check("t4_done", done8, 1'b0);
        step(0, 3'b000, 8'h00, 0, "t4_hold");
        rstn = 1'b1;

        // Clear to RESET_VAL and parity values.
        step(1, 3'b001, 8'h07, 0, "t5_ld7");
        check("t5_par7", par8, exp_parity(8'h07));
        step(1, 3'b001, 8'h03, 0, "t5_ld3");
        check("t5_par3", par8, 1'b0);
        step(1, 3'b110, 8'h00, 0, "t5_clr");
        check("t5_rv", qrv, 8'h5A);
        check("t5_r0", q8, 8'h00);

        // Single-bit instance: rotates hold, burst is one shift.
        step(1, 3'b001, 8'h01, 0, "t6_ld");
        step(1, 3'b100, 8'h00, 0, "t6_rol");   check("t6_rol_c", q1, 1'b1);
        step(1, 3'b101, 8'h00, 0, "t6_ror");   check("t6_ror_c", q1, 1'b1);
        step(1, 3'b111, 8'h00, 0, "t6_go");    check("t6_busy", busy1, 1'b1);
        step(0, 3'b000, 8'h00, 0, "t6_sh");
        check("t6_done", done1, 1'b1);
        check("t6_q", q1, 1'b0);
        for (int k = 0; k < 8; k++) step(0, 3'b000, 8'h00, 0, "t6_flush");

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rnd_async");
                step(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), "rnd_inrst");
                rstn = 1'b1;
            end else begin
                step(($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 1'($urandom), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
